// File: rtl/mic1_pkg.sv
// Shared types for the mic1 memory bridge: word width and the bridge FSM state.
package mic1_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA    = 2'd1,
    FETCH   = 2'd2,
    RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/mic1_fetch_buf.sv
// One-word instruction fetch buffer: holds the last fetched word, its word-address tag
// and a valid bit, and picks the big-endian byte addressed by the PC.
module mic1_fetch_buf
  import mic1_pkg::*;
#(
  parameter int FETCH_BUF_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_word,
  input  logic              inval,
  input  logic [WORD_W-1:0] addr_instr,
  output logic              hit,
  output logic [WORD_W-3:0] tag,
  output logic [7:0]        rd_byte
);

  logic              valid;
  logic [WORD_W-1:0] word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      word  <= '0;
      tag   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      word  <= load_word;
      tag   <= addr_instr[WORD_W-1:2];
    end else if (inval) begin
      valid <= 1'b0;
    end
  end

  // With the buffer disabled every fetch misses, but the byte still comes from the buffer.
  assign hit = (FETCH_BUF_EN != 0) && valid && (tag == addr_instr[WORD_W-1:2]);

  always_comb begin
    rd_byte = word[31:24];
    case (addr_instr[1:0])
      2'd0: rd_byte = word[31:24];
      2'd1: rd_byte = word[23:16];
      2'd2: rd_byte = word[15:8];
      2'd3: rd_byte = word[7:0];
      default: rd_byte = word[31:24];
    endcase
  end

endmodule

// File: rtl/mic1_mem_bridge.sv
// Bridges the mic1 core's data and instruction requests onto a single request/ack bus,
// stalling the core through core_run until the access is complete.
module mic1_mem_bridge
  import mic1_pkg::*;
#(
  parameter int FETCH_BUF_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_in,
  output logic              core_run,
  input  logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_fetch,
  input  logic [WORD_W-1:0] mem_addr_instr,
  output logic [WORD_W-1:0] mem_rdata,
  output logic [7:0]        mem_rd_instr,
  output logic              bus_req,
  output logic              bus_we,
  output logic [WORD_W-1:0] bus_addr,
  output logic [WORD_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [WORD_W-1:0] bus_rdata,
  output state_t            fsm_state
);

  state_t            state, state_next;
  logic              hit, data_miss, fetch_miss, miss, tag_match, fetch_pend;
  logic              buf_load, buf_inval;
  logic [WORD_W-3:0] tag;

  assign data_miss  = mem_read | mem_write;
  assign fetch_miss = mem_fetch & ~hit;
  assign miss       = data_miss | fetch_miss;
  assign tag_match  = (mem_addr == {2'b00, tag});
  // A write to the buffered word kills the hit, so a fetch of that word must go to the bus.
  assign fetch_pend = mem_fetch & ~(hit & ~(mem_write & tag_match));
  assign buf_inval  = (state == DATA) & bus_ack & mem_write & tag_match;
  assign buf_load   = (state == FETCH) & bus_ack;
  assign core_run   = run_in & ((state == RELEASE) | ((state == IDLE) & ~miss));
  assign fsm_state  = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Bus handshake: bus_req is the valid, bus_ack is a one-cycle completion pulse. While
  // bus_req is high, addr/we/wdata come straight from core inputs that are held during the
  // stall, so they stay stable until the ack edge; ack in IDLE or RELEASE is ignored.
  always_comb begin
    state_next = state;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_wdata  = '0;
    case (state)
      IDLE: begin
        if (run_in) begin
          if (data_miss)       state_next = DATA;
          else if (fetch_miss) state_next = FETCH;
        end
      end
      DATA: begin
        bus_req   = 1'b1;
        bus_we    = mem_write;
        bus_addr  = mem_addr;
        bus_wdata = mem_wdata;
        if (bus_ack) state_next = fetch_pend ? FETCH : RELEASE;
      end
      FETCH: begin
        bus_req  = 1'b1;
        bus_addr = {2'b00, mem_addr_instr[WORD_W-1:2]};
        if (bus_ack) state_next = RELEASE;
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A combined read+write returns the write data without a second bus access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rdata <= '0;
    end else if ((state == DATA) && bus_ack && mem_read) begin
      mem_rdata <= mem_write ? mem_wdata : bus_rdata;
    end
  end

  mic1_fetch_buf #(
    .FETCH_BUF_EN(FETCH_BUF_EN)
  ) u_fetch_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (buf_load),
    .load_word (bus_rdata),
    .inval     (buf_inval),
    .addr_instr(mem_addr_instr),
    .hit       (hit),
    .tag       (tag),
    .rd_byte   (mem_rd_instr)
  );

endmodule

// File: tb/tb_mic1_mem_bridge.sv
// Bench for mic1_mem_bridge: a bus responder backed by a word memory, and a reference
// model that predicts bus traffic, stall length, read data and instruction bytes.
module tb_mic1_mem_bridge;
  import mic1_pkg::*;

  localparam int TW = 65;

  logic        clk;
  logic        reset;
  logic        run_in;
  logic        core_run;
  logic [31:0] mem_addr, mem_wdata, mem_addr_instr, mem_rdata;
  logic        mem_read, mem_write, mem_fetch;
  logic [7:0]  mem_rd_instr;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  state_t      fsm_state;

  int checks = 0;
  int errors = 0;

  logic [31:0]   mem [int unsigned];
  logic [TW-1:0] act_q[$];
  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] cap;
  int            bus_wait = 0;
  int            wait_cnt;
  bit            in_txn;
  int            unstable_cnt = 0;
  int            spur_cnt = 0;
  int            spur_done = 0;

  bit          m_valid;
  logic [29:0] m_tag;
  logic [31:0] m_rdata;

  mic1_mem_bridge #(.FETCH_BUF_EN(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .run_in        (run_in),
    .core_run      (core_run),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_fetch     (mem_fetch),
    .mem_addr_instr(mem_addr_instr),
    .mem_rdata     (mem_rdata),
    .mem_rd_instr  (mem_rd_instr),
    .bus_req       (bus_req),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_ack       (bus_ack),
    .bus_rdata     (bus_rdata),
    .fsm_state     (fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  // bus responder: acks after bus_wait extra cycles, logs each completed transaction
  initial begin
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    wait_cnt  = 0;
    in_txn    = 1'b0;
    cap       = '0;
    mem[32'h14] = 32'hDEADBEEF;
    mem[32'h40] = 32'h11223344;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (reset) begin
        wait_cnt = 0;
        in_txn   = 1'b0;
      end else if (spur_done != spur_cnt) begin
        spur_done = spur_cnt;
        bus_rdata = 32'hBAD00BAD;
        bus_ack   = 1'b1;
      end else if (bus_req) begin
        if (!in_txn) begin
          cap    = {bus_we, bus_addr, bus_we ? bus_wdata : 32'h0};
          in_txn = 1'b1;
        end
        if (wait_cnt >= bus_wait) begin
          if (cap !== {bus_we, bus_addr, bus_we ? bus_wdata : 32'h0}) unstable_cnt++;
          act_q.push_back(cap);
          if (bus_we) mem[bus_addr] = bus_wdata;
          else        bus_rdata = mem_rd(bus_addr);
          bus_ack  = 1'b1;
          in_txn   = 1'b0;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        in_txn   = 1'b0;
      end
    end
  end

  // Driver + model for one core access; called right at a falling edge.
  task automatic do_access(input bit rd, input bit wr, input bit fe, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] pc, input int w,
                           input string name);
    int          stall, exp_stall, base, u0, sh;
    bit          fmiss;
    logic [29:0] pword;
    logic [31:0] exp_rdata, exp_word;
    logic [7:0]  exp_byte;
    pword = pc[31:2];
    exp_q.delete();
    if (rd || wr) exp_q.push_back({wr, addr, wr ? wdata : 32'h0});
    if (wr && addr == {2'b00, m_tag}) m_valid = 1'b0;
    fmiss = fe && !(m_valid && m_tag == pword);
    if (fmiss) exp_q.push_back({1'b0, 2'b00, pword, 32'h0});
    exp_stall = (exp_q.size() == 0) ? 0 : 1 + exp_q.size() * (w + 1);
    exp_rdata = rd ? (wr ? wdata : mem_rd(addr)) : m_rdata;
    exp_word  = (wr && addr == {2'b00, pword}) ? wdata : mem_rd({2'b00, pword});
    sh        = 24 - 8 * int'(pc[1:0]);
    exp_byte  = 8'(exp_word >> sh);

    bus_wait       = w;
    base           = act_q.size();
    u0             = unstable_cnt;
    mem_read       = rd;
    mem_write      = wr;
    mem_fetch      = fe;
    mem_addr       = addr;
    mem_wdata      = wdata;
    mem_addr_instr = pc;
    #1;
    stall = 0;
    while (!core_run && stall <= 60) begin
      stall++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (stall !== exp_stall) begin
      errors++;
      $display("FAIL %s stall: got %0d cycles, expected %0d", name, stall, exp_stall);
    end
    if (exp_stall > 0) begin
      checks++;
      if (fsm_state !== RELEASE) begin
        errors++;
        $display("FAIL %s release_state: got %0d, expected %0d", name, fsm_state, RELEASE);
      end
    end
    if (rd) begin
      checks++;
      if (mem_rdata !== exp_rdata) begin
        errors++;
        $display("FAIL %s mem_rdata: got %h, expected %h", name, mem_rdata, exp_rdata);
      end
    end
    if (fe) begin
      checks++;
      if (mem_rd_instr !== exp_byte) begin
        errors++;
        $display("FAIL %s mem_rd_instr: got %h, expected %h", name, mem_rd_instr, exp_byte);
      end
    end
    checks++;
    if (act_q.size() - base != exp_q.size()) begin
      errors++;
      $display("FAIL %s txn_count: got %0d, expected %0d", name, act_q.size() - base, exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (act_q[base + k] !== exp_q[k]) begin
          errors++;
          $display("FAIL %s txn%0d: got %h, expected %h", name, k, act_q[base + k], exp_q[k]);
        end
      end
    end
    checks++;
    if (unstable_cnt != u0) begin
      errors++;
      $display("FAIL %s bus_stable: got %0d changes, expected 0", name, unstable_cnt - u0);
    end
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_fetch = 1'b0;
    if (fmiss) begin
      m_valid = 1'b1;
      m_tag   = pword;
    end
    if (rd) m_rdata = exp_rdata;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    run_in         = 1'b1;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_fetch      = 1'b0;
    mem_addr       = 32'h0;
    mem_wdata      = 32'h0;
    mem_addr_instr = 32'h0;
    m_valid        = 1'b0;
    m_tag          = '0;
    m_rdata        = 32'h0;
    @(negedge clk);
    #1;
    checks++;
    if ({bus_req, bus_we} !== 2'b00 || bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: got req=%b we=%b addr=%h wdata=%h, expected all 0",
               bus_req, bus_we, bus_addr, bus_wdata);
    end
    checks++;
    if (fsm_state !== IDLE || mem_rdata !== 32'h0 || mem_rd_instr !== 8'h0) begin
      errors++;
      $display("FAIL reset_state: got state=%0d rdata=%h instr=%h, expected 0/0/0",
               fsm_state, mem_rdata, mem_rd_instr);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    do_access(1'b1, 1'b0, 1'b0, 32'h14, 32'h0, 32'h0, 1, "read");
  endtask

  task automatic test_fetch();
    do_access(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h101, 1, "fetch_miss");
    do_access(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h102, 0, "fetch_hit");
  endtask

  task automatic test_combined();
    do_access(1'b1, 1'b0, 1'b1, 32'h8, 32'h0, 32'h200, 1, "combined");
  endtask

  task automatic test_invalidate();
    do_access(1'b0, 1'b1, 1'b0, 32'h80, $urandom, 32'h0, 0, "inval_write");
    do_access(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h200, 1, "inval_refetch");
  endtask

  task automatic test_read_write();
    do_access(1'b1, 1'b1, 1'b0, 32'h30, 32'hCAFEF00D, 32'h0, 2, "read_write");
  endtask

  task automatic test_spurious_ack();
    spur_cnt++;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (fsm_state !== IDLE || mem_rdata !== m_rdata || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL spurious_ack: got state=%0d rdata=%h req=%b, expected 0/%h/0",
               fsm_state, mem_rdata, bus_req, m_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_run_gating();
    int base;
    base      = act_q.size();
    run_in    = 1'b0;
    mem_read  = 1'b1;
    mem_addr  = 32'h14;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus_req !== 1'b0 || core_run !== 1'b0) begin
        errors++;
        $display("FAIL run_gating cycle %0d: got req=%b core_run=%b, expected 0/0", i, bus_req, core_run);
      end
      @(negedge clk);
      #1;
    end
    checks++;
    if (act_q.size() != base) begin
      errors++;
      $display("FAIL run_gating_txn: got %0d transactions, expected 0", act_q.size() - base);
    end
    @(negedge clk);
    mem_read = 1'b0;
    run_in   = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_fetch();
    int base;
    do_access(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h300, 0, "pre_reset_fetch");
    bus_wait       = 6;
    mem_fetch      = 1'b1;
    mem_addr_instr = 32'h305;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (fsm_state !== FETCH || bus_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_fetch: got state=%0d req=%b, expected %0d/1", fsm_state, bus_req, FETCH);
    end
    #2;
    reset     = 1'b1;
    mem_fetch = 1'b0;
    #1;
    checks++;
    if (bus_req !== 1'b0 || fsm_state !== IDLE) begin
      errors++;
      $display("FAIL async_reset_bus: got req=%b state=%0d, expected 0/%0d", bus_req, fsm_state, IDLE);
    end
    checks++;
    if (mem_rd_instr !== 8'h0 || mem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL async_reset_data: got instr=%h rdata=%h, expected 00/0", mem_rd_instr, mem_rdata);
    end
    base = act_q.size();
    @(negedge clk);
    reset   = 1'b0;
    m_valid = 1'b0;
    m_tag   = '0;
    m_rdata = 32'h0;
    repeat (4) @(negedge clk);
    checks++;
    if (act_q.size() != base) begin
      errors++;
      $display("FAIL no_reissue: got %0d transactions, expected 0", act_q.size() - base);
    end
    do_access(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h300, 1, "post_reset_fetch");
  endtask

  task automatic test_random();
    logic [31:0] addr_pool [6] = '{32'h40, 32'h41, 32'h80, 32'h14, 32'h20, 32'h21};
    logic [31:0] word_pool [5] = '{32'h40, 32'h41, 32'h42, 32'h80, 32'hC0};
    for (int i = 0; i < 40; i++) begin
      bit          rd, wr, fe;
      logic [31:0] a, pc;
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 3) == 0);
      fe = 1'($urandom_range(0, 1));
      if (!rd && !wr) fe = 1'b1;
      a  = addr_pool[$urandom_range(0, 5)];
      pc = (word_pool[$urandom_range(0, 4)] << 2) | 32'($urandom_range(0, 3));
      do_access(rd, wr, fe, a, $urandom, pc, $urandom_range(0, 3), "random");
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    do_access(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h108, 0, "b2b_fetch");
    do_access(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h109, 0, "b2b_hit1");
    do_access(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h10B, 0, "b2b_hit2");
    do_access(1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 32'h10A, 2, "b2b_read_hit");
    do_access(1'b0, 1'b1, 1'b1, 32'h42, 32'h55667788, 32'h10A, 0, "b2b_write_refetch");
  endtask

  initial begin
    test_reset();
    test_read();
    test_fetch();
    test_combined();
    test_invalidate();
    test_read_write();
    test_spurious_ack();
    test_run_gating();
    test_reset_mid_fetch();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
